// File: rtl/axi4lite_pkg.sv
// axi4lite_pkg: shared widths, FSM state encoding and response codes for the
// AXI4-Lite demonstrator tile (axi4lite_top and axi4lite_regfile_slave).
package axi4lite_pkg;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 8;
  localparam int NREGS  = 1 << ADDR_W;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/axi4lite_regfile_slave.sv
// axi4lite_regfile_slave: always-ready AXI4-Lite slave holding NREGS x DATA_W
// registers. Single outstanding transaction per channel; responses are OKAY.
module axi4lite_regfile_slave
  import axi4lite_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  // write address / data / response
  input  logic [ADDR_W-1:0] i_awaddr,
  input  logic              i_awvalid,
  output logic              o_awready,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_wvalid,
  output logic              o_wready,
  output logic [1:0]        o_bresp,
  output logic              o_bvalid,
  input  logic              i_bready,
  // read address / data
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic              i_arvalid,
  output logic              o_arready,
  output logic [DATA_W-1:0] o_rdata,
  output logic [1:0]        o_rresp,
  output logic              o_rvalid,
  input  logic              i_rready
);

  logic [DATA_W-1:0] r_regs [0:NREGS-1];
  logic              r_bvalid;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  wire w_wr_hs = i_awvalid && i_wvalid;   // both READYs are tied high
  wire w_rd_hs = i_arvalid;

  assign o_awready = 1'b1;
  assign o_wready  = 1'b1;
  assign o_arready = 1'b1;
  assign o_bresp   = RESP_OKAY;
  assign o_rresp   = RESP_OKAY;
  assign o_bvalid  = r_bvalid;
  assign o_rvalid  = r_rvalid;
  assign o_rdata   = r_rdata;

  // Register file update and B/R valid flags; a new handshake takes priority
  // over retiring the previous response.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_bvalid <= 1'b0;
      r_rvalid <= 1'b0;
    end else begin
      if (r_bvalid && i_bready) r_bvalid <= 1'b0;
      if (w_wr_hs) begin
        r_regs[i_awaddr] <= i_wdata;
        r_bvalid         <= 1'b1;
      end
      if (r_rvalid && i_rready) r_rvalid <= 1'b0;
      if (w_rd_hs) r_rvalid <= 1'b1;
    end
  end

  // Read data capture; pure datapath, qualified downstream by RVALID.
  always_ff @(posedge clk) begin
    if (w_rd_hs) r_rdata <= r_regs[i_araddr];
  end

endmodule

// File: rtl/axi4lite_top.sv
// axi4lite_top: tile top level. A master FSM turns pin-level start strobes into
// single-beat AXI4-Lite writes/reads against axi4lite_regfile_slave.
// Optional macro AXI4LITE_STATUS_EN exposes busy/state/last response on uo_out[7:1].
module axi4lite_top
  import axi4lite_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_uio_out;
  logic [7:0]        r_uio_oe;
  logic              r_done;
`ifdef AXI4LITE_STATUS_EN
  logic [1:0]        r_last_resp;
`endif

  logic              w_awready;
  logic              w_wready;
  logic [1:0]        w_bresp;
  logic              w_bvalid;
  logic              w_arready;
  logic [DATA_W-1:0] w_rdata;
  logic [1:0]        w_rresp;
  logic              w_rvalid;

  wire w_start_wr = ui_in[0];
  wire w_start_rd = ui_in[4];

  // Channel VALID/READY driven by the master are decoded from the state register.
  wire w_awvalid = (r_state == S_WADDR);
  wire w_wvalid  = (r_state == S_WADDR);
  wire w_bready  = (r_state == S_WRESP);
  wire w_arvalid = (r_state == S_RADDR);
  wire w_rready  = (r_state == S_RDATA);

  axi4lite_regfile_slave u_slave (
    .clk       (clk),
    .rst       (rst),
    .i_awaddr  (r_addr),
    .i_awvalid (w_awvalid),
    .o_awready (w_awready),
    .i_wdata   (r_wdata),
    .i_wvalid  (w_wvalid),
    .o_wready  (w_wready),
    .o_bresp   (w_bresp),
    .o_bvalid  (w_bvalid),
    .i_bready  (w_bready),
    .i_araddr  (r_addr),
    .i_arvalid (w_arvalid),
    .o_arready (w_arready),
    .o_rdata   (w_rdata),
    .o_rresp   (w_rresp),
    .o_rvalid  (w_rvalid),
    .i_rready  (w_rready)
  );

  // Master FSM: latch request in IDLE, walk the AXI channels, pulse done once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_uio_out   <= '0;
      r_uio_oe    <= 8'h00;
      r_done      <= 1'b0;
`ifdef AXI4LITE_STATUS_EN
      r_last_resp <= RESP_OKAY;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_start_wr) begin
            r_addr   <= ui_in[2:1];
            r_wdata  <= uio_in;
            r_uio_oe <= 8'h00;
            r_state  <= S_WADDR;
          end else if (w_start_rd) begin
            r_addr  <= ui_in[3:2];
            r_state <= S_RADDR;
          end
        end
        S_WADDR: begin
          if (w_awready && w_wready) r_state <= S_WRESP;
        end
        S_WRESP: begin
          if (w_bvalid) begin
`ifdef AXI4LITE_STATUS_EN
            r_last_resp <= w_bresp;
`endif
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_RADDR: begin
          if (w_arready) r_state <= S_RDATA;
        end
        S_RDATA: begin
          if (w_rvalid) begin
            r_uio_out <= w_rdata;
            r_uio_oe  <= 8'hFF;
`ifdef AXI4LITE_STATUS_EN
            r_last_resp <= w_rresp;
`endif
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign uio_out = r_uio_out;
  assign uio_oe  = r_uio_oe;

`ifdef AXI4LITE_STATUS_EN
  assign uo_out = {1'b0, r_last_resp, 3'(r_state), (r_state != S_IDLE), r_done};
  wire w_unused = &{1'b0, ena, ui_in[7:5]};
`else
  assign uo_out = {7'b0, r_done};
  wire w_unused = &{1'b0, ena, ui_in[7:5], w_bresp, w_rresp};
`endif

endmodule

// File: tb/tb_axi4lite_top.sv
// tb_axi4lite_top: randomized scoreboard bench for axi4lite_top. Stimulus pushes
// the expected completion (cycle, uio_out, uio_oe) computed from a register-array
// model; a forked monitor pops and compares on every done pulse.
module tb_axi4lite_top;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;
  wire  [7:0] uo_out;

  axi4lite_top dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .uo_out  (uo_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] exp_out;
    logic [7:0] exp_oe;
    int         exp_cyc;
  } exp_t;

  exp_t       q[$];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] m_regs [4];
  logic [7:0] m_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] junk3();
    logic [31:0] r;
    r = $urandom();
    return r[2:0];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_last = 8'h00;
  endfunction

  // Drive a one-cycle write strobe (optionally with start_read too) and record it.
  task automatic issue_wr(input logic [1:0] a, input logic [7:0] d, input bit also_rd);
    exp_t e;
    ui_in  = {junk3(), also_rd, 1'b0, a, 1'b1};
    uio_in = d;
    m_regs[a] = d;
    e.exp_out = m_last;
    e.exp_oe  = 8'h00;
    e.exp_cyc = cyc + 3;
    q.push_back(e);
    @(negedge clk);
    ui_in  = 8'h00;
    uio_in = 8'($urandom());
  endtask

  task automatic issue_rd(input logic [1:0] a);
    exp_t e;
    ui_in  = {junk3(), 1'b1, a, 2'b00};
    uio_in = 8'($urandom());
    m_last = m_regs[a];
    e.exp_out = m_last;
    e.exp_oe  = 8'hFF;
    e.exp_cyc = cyc + 3;
    q.push_back(e);
    @(negedge clk);
    ui_in = 8'h00;
  endtask

  // Wait (bounded) for the monitor to retire all expectations, then one idle cycle.
  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout pending=%0d required=0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    model_reset();

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && uo_out[0]) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done uo_out=%0h required=no pulse", uo_out);
          end else begin
            e = q.pop_front();
            chk("done_cycle", cyc, e.exp_cyc);
            chk("uio_out", uio_out, e.exp_out);
            chk("uio_oe", uio_oe, e.exp_oe);
`ifdef AXI4LITE_STATUS_EN
            chk("status_bits", uo_out & 8'hE3, 8'h03);
`else
            chk("uo_out_upper", uo_out[7:1], 7'h00);
`endif
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_uo_out", uo_out, 8'h00);
    chk("rst_uio_out", uio_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // unwritten register after reset
    issue_rd(2'd3); wait_done();

    // basic write then read
    issue_wr(2'd2, 8'h04, 1'b0); wait_done();
    issue_rd(2'd2); wait_done();

    // all four registers
    issue_wr(2'd0, 8'h11, 1'b0); wait_done();
    issue_wr(2'd1, 8'h22, 1'b0); wait_done();
    issue_wr(2'd2, 8'h33, 1'b0); wait_done();
    issue_wr(2'd3, 8'h44, 1'b0); wait_done();
    for (int i = 0; i < 4; i++) begin
      issue_rd(2'(i)); wait_done();
    end

    // simultaneous start: write wins, one done pulse
    issue_wr(2'd0, 8'h99, 1'b1); wait_done();
    issue_rd(2'd0); wait_done();

    // strobes while busy are ignored (write data 0xEE to addr 3 must not land)
    issue_wr(2'd1, 8'h5A, 1'b0);
    for (int k = 0; k < 3; k++) begin
      ui_in  = {3'b000, 1'b1, 1'b1, 2'd3, 1'b1};
      uio_in = 8'hEE;
      @(negedge clk);
    end
    ui_in = 8'h00;
    wait_done();
    issue_rd(2'd3); wait_done();
    issue_rd(2'd1); wait_done();

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [31:0] r;
      r = $urandom();
      if (r[0]) issue_wr(r[2:1], r[15:8], 1'b0);
      else      issue_rd(r[2:1]);
      wait_done();
    end

    // reset asserted while in WADDR aborts the write
    issue_wr(2'd2, 8'hC3, 1'b0);
    void'(q.pop_back());
    rst   = 1'b1;
    ui_in = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    chk("abort_uo_out", uo_out, 8'h00);
    chk("abort_uio_oe", uio_oe, 8'h00);
    chk("abort_uio_out", uio_out, 8'h00);
    issue_rd(2'd2); wait_done();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
